// File: rtl/mem_wb_reg_pkg.sv
// Shared MIPS core constants: instruction codes, datapath width and link offset.
// Also provides classification helpers used by the MEM/WB register.
package mem_wb_reg_pkg;

    localparam int XLEN        = 32;
    localparam int LINK_OFFSET = 8;

    localparam logic [7:0] NOP_CODE = 8'h00;
    localparam logic [7:0] ADD      = 8'h01;
    localparam logic [7:0] ADDU     = 8'h02;
    localparam logic [7:0] SUB      = 8'h03;
    localparam logic [7:0] SUBU     = 8'h04;
    localparam logic [7:0] AND_I    = 8'h05;
    localparam logic [7:0] OR_I     = 8'h06;
    localparam logic [7:0] XOR_I    = 8'h07;
    localparam logic [7:0] NOR_I    = 8'h08;
    localparam logic [7:0] SLT      = 8'h09;
    localparam logic [7:0] SLTU     = 8'h0A;
    localparam logic [7:0] SLL      = 8'h0B;
    localparam logic [7:0] SRL      = 8'h0C;
    localparam logic [7:0] SRA      = 8'h0D;
    localparam logic [7:0] SLLV     = 8'h0E;
    localparam logic [7:0] SRLV     = 8'h0F;
    localparam logic [7:0] SRAV     = 8'h10;
    localparam logic [7:0] ADDI     = 8'h11;
    localparam logic [7:0] ADDIU    = 8'h12;
    localparam logic [7:0] SLTI     = 8'h13;
    localparam logic [7:0] SLTIU    = 8'h14;
    localparam logic [7:0] ANDI     = 8'h15;
    localparam logic [7:0] ORI      = 8'h16;
    localparam logic [7:0] XORI     = 8'h17;
    localparam logic [7:0] LUI      = 8'h18;
    localparam logic [7:0] MULT     = 8'h19;
    localparam logic [7:0] MULTU    = 8'h1A;
    localparam logic [7:0] DIV      = 8'h1B;
    localparam logic [7:0] DIVU     = 8'h1C;
    localparam logic [7:0] MFHI     = 8'h1D;
    localparam logic [7:0] MFLO     = 8'h1E;
    localparam logic [7:0] MTHI     = 8'h1F;
    localparam logic [7:0] MTLO     = 8'h20;
    localparam logic [7:0] BEQ      = 8'h21;
    localparam logic [7:0] BNE      = 8'h22;
    localparam logic [7:0] BGEZ     = 8'h23;
    localparam logic [7:0] BGTZ     = 8'h24;
    localparam logic [7:0] BLEZ     = 8'h25;
    localparam logic [7:0] BLTZ     = 8'h26;
    localparam logic [7:0] BGEZAL   = 8'h27;
    localparam logic [7:0] BLTZAL   = 8'h28;
    localparam logic [7:0] J        = 8'h29;
    localparam logic [7:0] JAL      = 8'h2A;
    localparam logic [7:0] JR       = 8'h2B;
    localparam logic [7:0] JALR     = 8'h2C;
    localparam logic [7:0] LB       = 8'h2D;
    localparam logic [7:0] LBU      = 8'h2E;
    localparam logic [7:0] LH       = 8'h2F;
    localparam logic [7:0] LHU      = 8'h30;
    localparam logic [7:0] LW       = 8'h31;
    localparam logic [7:0] SB       = 8'h32;
    localparam logic [7:0] SH       = 8'h33;
    localparam logic [7:0] SW       = 8'h34;
    localparam logic [7:0] SYSCALL  = 8'h35;
    localparam logic [7:0] BREAK    = 8'h36;
    localparam logic [7:0] ERET     = 8'h37;
    localparam logic [7:0] MFC0     = 8'h38;
    localparam logic [7:0] MTC0     = 8'h39;

    function automatic logic is_load(input logic [7:0] code);
        return (code == LB) || (code == LBU) || (code == LH) ||
               (code == LHU) || (code == LW);
    endfunction

    function automatic logic is_link(input logic [7:0] code);
        return (code == JAL) || (code == JALR) ||
               (code == BLTZAL) || (code == BGEZAL);
    endfunction

    // Instructions that never write a GPR, even if decode raised reg_we.
    function automatic logic never_writes(input logic [7:0] code);
        case (code)
            SB, SH, SW,
            BEQ, BNE, BGEZ, BGTZ, BLEZ, BLTZ, J, JR,
            MTHI, MTLO, SYSCALL, BREAK, ERET: return 1'b1;
            default:                          return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_wb_reg_load_align.sv
// Combinational load aligner: picks the addressed byte/halfword from the raw
// memory word (little-endian), extends it, and flags misaligned accesses.
module load_align
    import mem_wb_reg_pkg::*;
#(
    parameter int XLEN_P = 32
) (
    input  logic [7:0]        inst_name,
    input  logic [1:0]        offset,
    input  logic [XLEN_P-1:0] raw,
    output logic [XLEN_P-1:0] aligned,
    output logic              misaligned
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        case (offset)
            2'd0:    byte_sel = raw[7:0];
            2'd1:    byte_sel = raw[15:8];
            2'd2:    byte_sel = raw[23:16];
            default: byte_sel = raw[31:24];
        endcase
        half_sel = offset[1] ? raw[31:16] : raw[15:0];
    end

    always_comb begin
        aligned    = raw;
        misaligned = 1'b0;
        case (inst_name)
            LB:  aligned = {{(XLEN_P-8){byte_sel[7]}}, byte_sel};
            LBU: aligned = {{(XLEN_P-8){1'b0}}, byte_sel};
            LH: begin
                aligned    = {{(XLEN_P-16){half_sel[15]}}, half_sel};
                misaligned = offset[0];
            end
            LHU: begin
                aligned    = {{(XLEN_P-16){1'b0}}, half_sel};
                misaligned = offset[0];
            end
            LW: misaligned = (offset != 2'd0);
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register: aligns loads, selects GPR write data, qualifies the
// write enable, and applies flush/stall. Optional macro MEM_WB_RETIRE_CNT_EN.
module mem_wb_reg
    import mem_wb_reg_pkg::*;
#(
    parameter logic [7:0] NOP_CODE = 8'h00,
    parameter int         XLEN     = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall,
    input  logic            flush,
    input  logic            mem_valid,
    input  logic [7:0]      mem_inst_name,
    input  logic [XLEN-1:0] mem_pc,
    input  logic [XLEN-1:0] mem_alu_result,
    input  logic [XLEN-1:0] mem_rdata,
    input  logic [4:0]      mem_dest,
    input  logic            mem_reg_we,
    output logic            wb_valid,
    output logic [7:0]      wb_inst_name,
    output logic [XLEN-1:0] wb_pc,
    output logic [4:0]      wb_dest,
    output logic            wb_we,
    output logic [XLEN-1:0] wb_wdata,
    output logic            wb_adel
`ifdef MEM_WB_RETIRE_CNT_EN
    ,
    output logic [31:0]     retire_cnt
`endif
);

    logic [XLEN-1:0] aligned_p0;
    logic            misaligned_p0;
    logic            load_p0;
    logic            we_p0;
    logic            adel_p0;
    logic [XLEN-1:0] wdata_p0;

    load_align #(.XLEN_P(XLEN)) u_load_align (
        .inst_name  (mem_inst_name),
        .offset     (mem_alu_result[1:0]),
        .raw        (mem_rdata),
        .aligned    (aligned_p0),
        .misaligned (misaligned_p0)
    );

    always_comb begin
        load_p0 = is_load(mem_inst_name);
        adel_p0 = mem_valid & load_p0 & misaligned_p0;
        we_p0   = mem_valid & mem_reg_we & (mem_dest != 5'd0) &
                  ~adel_p0 & ~never_writes(mem_inst_name);
        if (load_p0)
            wdata_p0 = aligned_p0;
        else if (is_link(mem_inst_name))
            wdata_p0 = mem_pc + XLEN'(LINK_OFFSET);
        else
            wdata_p0 = mem_alu_result;
    end

    // ---- stage boundary: MEM -> WB ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_valid     <= 1'b0;
            wb_inst_name <= NOP_CODE;
            wb_pc        <= '0;
            wb_dest      <= '0;
            wb_we        <= 1'b0;
            wb_wdata     <= '0;
            wb_adel      <= 1'b0;
        end else if (flush || (!stall && !mem_valid)) begin
            wb_valid     <= 1'b0;
            wb_inst_name <= NOP_CODE;
            wb_pc        <= '0;
            wb_dest      <= '0;
            wb_we        <= 1'b0;
            wb_wdata     <= '0;
            wb_adel      <= 1'b0;
        end else if (!stall) begin
            wb_valid     <= 1'b1;
            wb_inst_name <= mem_inst_name;
            wb_pc        <= mem_pc;
            wb_dest      <= mem_dest;
            wb_we        <= we_p0;
            wb_wdata     <= wdata_p0;
            wb_adel      <= adel_p0;
        end
    end

`ifdef MEM_WB_RETIRE_CNT_EN
    // Counts entries leaving WB; a later flush only affects the incoming entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            retire_cnt <= '0;
        else if (wb_valid && !wb_adel && !stall)
            retire_cnt <= retire_cnt + 32'd1;
    end
`endif

endmodule

// File: tb/tb_mem_wb_reg.sv
// Directed scoreboard bench for mem_wb_reg: expectations are queued at drive
// time and compared one cycle later with immediate assertions.
module tb_mem_wb_reg;
    import mem_wb_reg_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic        mem_valid = 1'b0;
    logic [7:0]  mem_inst_name = 8'h00;
    logic [31:0] mem_pc = '0;
    logic [31:0] mem_alu_result = '0;
    logic [31:0] mem_rdata = '0;
    logic [4:0]  mem_dest = '0;
    logic        mem_reg_we = 1'b0;
    logic        wb_valid;
    logic [7:0]  wb_inst_name;
    logic [31:0] wb_pc;
    logic [4:0]  wb_dest;
    logic        wb_we;
    logic [31:0] wb_wdata;
    logic        wb_adel;
`ifdef MEM_WB_RETIRE_CNT_EN
    logic [31:0] retire_cnt;
`endif

    int compared = 0;
    int mismatched = 0;

    typedef struct {
        logic        v;
        logic [7:0]  inst;
        logic [31:0] pc;
        logic [4:0]  dest;
        logic        we;
        logic [31:0] wdata;
        logic        adel;
    } exp_t;

    exp_t sb[$];

    mem_wb_reg dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .stall          (stall),
        .flush          (flush),
        .mem_valid      (mem_valid),
        .mem_inst_name  (mem_inst_name),
        .mem_pc         (mem_pc),
        .mem_alu_result (mem_alu_result),
        .mem_rdata      (mem_rdata),
        .mem_dest       (mem_dest),
        .mem_reg_we     (mem_reg_we),
        .wb_valid       (wb_valid),
        .wb_inst_name   (wb_inst_name),
        .wb_pc          (wb_pc),
        .wb_dest        (wb_dest),
        .wb_we          (wb_we),
        .wb_wdata       (wb_wdata),
        .wb_adel        (wb_adel)
`ifdef MEM_WB_RETIRE_CNT_EN
        ,
        .retire_cnt     (retire_cnt)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string tag, input exp_t e);
        check({tag, ".valid"}, 32'(wb_valid), 32'(e.v));
        check({tag, ".inst"},  32'(wb_inst_name), 32'(e.inst));
        check({tag, ".pc"},    wb_pc, e.pc);
        check({tag, ".dest"},  32'(wb_dest), 32'(e.dest));
        check({tag, ".we"},    32'(wb_we), 32'(e.we));
        check({tag, ".wdata"}, wb_wdata, e.wdata);
        check({tag, ".adel"},  32'(wb_adel), 32'(e.adel));
    endtask

    // Drive one cycle of stimulus at the falling edge, queue what WB must show
    // after the following rising edge, then pop and compare.
    task automatic step(input string tag,
                        input logic v, input logic [7:0] inst, input logic [31:0] pc,
                        input logic [31:0] alu, input logic [31:0] rdata,
                        input logic [4:0] dest, input logic rwe,
                        input logic st, input logic fl,
                        input logic e_v, input logic [7:0] e_inst, input logic [31:0] e_pc,
                        input logic [4:0] e_dest, input logic e_we,
                        input logic [31:0] e_wdata, input logic e_adel);
        exp_t e;
        @(negedge clk);
        mem_valid = v; mem_inst_name = inst; mem_pc = pc; mem_alu_result = alu;
        mem_rdata = rdata; mem_dest = dest; mem_reg_we = rwe; stall = st; flush = fl;
        e.v = e_v; e.inst = e_inst; e.pc = e_pc; e.dest = e_dest;
        e.we = e_we; e.wdata = e_wdata; e.adel = e_adel;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            check({tag, ".sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            check_outputs(tag, e);
        end
    endtask

    initial begin
        exp_t zero_e;
        zero_e.v = 1'b0; zero_e.inst = 8'h00; zero_e.pc = '0; zero_e.dest = '0;
        zero_e.we = 1'b0; zero_e.wdata = '0; zero_e.adel = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check_outputs("reset", zero_e);
        @(negedge clk);
        rst_n = 1'b1;

        // Loads on the 0x80FF_1234 word
        step("lb",   1, LB,  32'h0040_0000, 32'h0000_1003, 32'h80FF_1234, 5'd8, 1, 0, 0,
             1, LB,  32'h0040_0000, 5'd8, 1, 32'hFFFF_FF80, 0);
        step("lbu",  1, LBU, 32'h0040_0004, 32'h0000_1003, 32'h80FF_1234, 5'd9, 1, 0, 0,
             1, LBU, 32'h0040_0004, 5'd9, 1, 32'h0000_0080, 0);
        step("lh_mis", 1, LH, 32'h0040_0008, 32'h0000_1001, 32'h80FF_1234, 5'd10, 1, 0, 0,
             1, LH,  32'h0040_0008, 5'd10, 0, 32'h0000_1234, 1);
        step("lw",   1, LW,  32'h0040_000C, 32'h0000_1000, 32'h80FF_1234, 5'd11, 1, 0, 0,
             1, LW,  32'h0040_000C, 5'd11, 1, 32'h80FF_1234, 0);
        step("lh_hi", 1, LH, 32'h0040_0010, 32'h0000_1002, 32'h80FF_1234, 5'd12, 1, 0, 0,
             1, LH,  32'h0040_0010, 5'd12, 1, 32'hFFFF_80FF, 0);
        step("lhu_hi", 1, LHU, 32'h0040_0014, 32'h0000_1002, 32'h80FF_1234, 5'd13, 1, 0, 0,
             1, LHU, 32'h0040_0014, 5'd13, 1, 32'h0000_80FF, 0);
        step("lb_b1", 1, LB, 32'h0040_0018, 32'h0000_1001, 32'h80FF_1234, 5'd14, 1, 0, 0,
             1, LB,  32'h0040_0018, 5'd14, 1, 32'h0000_0012, 0);
        step("lw_mis", 1, LW, 32'h0040_001C, 32'h0000_1002, 32'h80FF_1234, 5'd15, 1, 0, 0,
             1, LW,  32'h0040_001C, 5'd15, 0, 32'h80FF_1234, 1);

        // Link, $0 suppression, never-write classes, pass-through
        step("jal",  1, JAL,  32'h0040_0010, 32'h1234_5678, 32'h0, 5'd31, 1, 0, 0,
             1, JAL,  32'h0040_0010, 5'd31, 1, 32'h0040_0018, 0);
        step("jalr_wrap", 1, JALR, 32'hFFFF_FFFC, 32'h0, 32'h0, 5'd31, 1, 0, 0,
             1, JALR, 32'hFFFF_FFFC, 5'd31, 1, 32'h0000_0004, 0);
        step("addu_r0", 1, ADDU, 32'h0040_0020, 32'hDEAD_BEEF, 32'h0, 5'd0, 1, 0, 0,
             1, ADDU, 32'h0040_0020, 5'd0, 0, 32'hDEAD_BEEF, 0);
        step("sw_nowr", 1, SW, 32'h0040_0024, 32'h0000_1001, 32'h0, 5'd5, 1, 0, 0,
             1, SW,   32'h0040_0024, 5'd5, 0, 32'h0000_1001, 0);
        step("mfhi", 1, MFHI, 32'h0040_0028, 32'hCAFE_0001, 32'h0, 5'd3, 1, 0, 0,
             1, MFHI, 32'h0040_0028, 5'd3, 1, 32'hCAFE_0001, 0);
        step("invalid", 0, LB, 32'h0040_002C, 32'h0000_1003, 32'h80FF_1234, 5'd8, 1, 0, 0,
             0, 8'h00, 32'h0, 5'd0, 0, 32'h0, 0);

        // Stall holds for three cycles despite changing inputs, then flush wins
        step("cap",  1, ADDU, 32'h0040_0030, 32'h0000_0055, 32'h0, 5'd7, 1, 0, 0,
             1, ADDU, 32'h0040_0030, 5'd7, 1, 32'h0000_0055, 0);
        for (int i = 0; i < 3; i++) begin
            step("stall", 1, SUBU, 32'h0050_0000 + 32'(i), 32'h0000_0AAA, 32'h0, 5'd4, 1, 1, 0,
                 1, ADDU, 32'h0040_0030, 5'd7, 1, 32'h0000_0055, 0);
        end
        step("stall_flush", 1, SUBU, 32'h0050_0010, 32'h0000_0AAA, 32'h0, 5'd4, 1, 1, 1,
             0, 8'h00, 32'h0, 5'd0, 0, 32'h0, 0);

        // Asynchronous reset between edges
        step("pre_rst", 1, ORI, 32'h0040_0040, 32'h0000_00F0, 32'h0, 5'd6, 1, 0, 0,
             1, ORI, 32'h0040_0040, 5'd6, 1, 32'h0000_00F0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check_outputs("async_rst", zero_e);
        @(negedge clk);
        rst_n = 1'b1;

`ifdef MEM_WB_RETIRE_CNT_EN
        check("retire_reset", retire_cnt, 32'd0);
        step("rc1", 1, ADDU, 32'h100, 32'h1, 32'h0, 5'd1, 1, 0, 0,
             1, ADDU, 32'h100, 5'd1, 1, 32'h1, 0);
        step("rc2", 1, ADDU, 32'h104, 32'h2, 32'h0, 5'd2, 1, 0, 0,
             1, ADDU, 32'h104, 5'd2, 1, 32'h2, 0);
        step("rc3", 1, LW, 32'h108, 32'h2001, 32'h0, 5'd3, 1, 0, 0,
             1, LW, 32'h108, 5'd3, 0, 32'h0, 1);
        step("rc4", 1, ADDU, 32'h10C, 32'h4, 32'h0, 5'd4, 1, 0, 0,
             1, ADDU, 32'h10C, 5'd4, 1, 32'h4, 0);
        step("rc5", 1, ADDU, 32'h110, 32'h5, 32'h0, 5'd5, 1, 0, 1,
             0, 8'h00, 32'h0, 5'd0, 0, 32'h0, 0);
        step("rc_idle", 0, ADDU, 32'h0, 32'h0, 32'h0, 5'd0, 0, 0, 0,
             0, 8'h00, 32'h0, 5'd0, 0, 32'h0, 0);
        check("retire_cnt", retire_cnt, 32'd3);
`endif

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
